// File: rtl/arcade_input_mapper_if.sv
// Arcade input mapper bus: PS/2 + joystick inputs, player control outputs.
// Master drives inputs, slave (the mapper) returns registered controls.
interface arcade_input_mapper_if #(
  parameter int PLAYERS = 2
);
  logic [10:0]          ps2_key;
  logic [16*PLAYERS-1:0] joy;
  logic [PLAYERS-1:0]   autofire_en;
  logic                 tick;
  logic [8*PLAYERS-1:0] ctrl;
  logic                 pause;
  logic                 key_reset;
  logic                 service;

  modport master (
    output ps2_key, joy, autofire_en, tick,
    input  ctrl, pause, key_reset, service
  );

  modport slave (
    input  ps2_key, joy, autofire_en, tick,
    output ctrl, pause, key_reset, service
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and joysticks into per-player control bytes with
// coin stretching, autofire and opposite-direction cleaning.
module arcade_input_mapper #(
  parameter int PLAYERS         = 2,
  parameter int COIN_MIN_CYCLES = 65536,
  parameter int AF_DIV          = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  arcade_input_mapper_if.slave    io
);
  localparam int          AW        = $clog2(AF_DIV + 1);
  localparam logic [16:0] COIN_LOAD = 17'(COIN_MIN_CYCLES - 1);

  typedef enum logic [1:0] {AF_IDLE, AF_ON, AF_OFF} af_t;

  logic       old_tgl_q;
  logic [7:0] kb_q [2];
  logic       key_reset_q;
  logic       service_q;
  logic       pause_q;
  logic       pause_d;
  logic       kb_ev;
  logic       pr;
  logic [8:0] code;

  assign kb_ev = io.ps2_key[10] != old_tgl_q;
  assign pr    = io.ps2_key[9];
  assign code  = io.ps2_key[8:0];

  // Latch bit order matches ctrl: {coin,start,bomb,fire,up,down,left,right}
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_tgl_q   <= 1'b0;
      kb_q[0]     <= '0;
      kb_q[1]     <= '0;
      key_reset_q <= 1'b0;
      service_q   <= 1'b0;
    end else begin
      old_tgl_q <= io.ps2_key[10];
      if (kb_ev) begin
        unique casez (code)
          9'h016:          kb_q[0][6]  <= pr;
          9'h01E:          kb_q[1][6]  <= pr;
          9'h02E:          kb_q[0][7]  <= pr;
          9'h036:          kb_q[1][7]  <= pr;
          9'h004:          key_reset_q <= pr;
          9'h046:          service_q   <= pr;
          9'b?_0111_0101:  kb_q[0][3]  <= pr;
          9'b?_0110_1011:  kb_q[0][1]  <= pr;
          9'b?_0111_0010:  kb_q[0][2]  <= pr;
          9'b?_0111_0100:  kb_q[0][0]  <= pr;
          9'h014:          kb_q[0][4]  <= pr;
          9'h011:          kb_q[0][5]  <= pr;
          9'h02D:          kb_q[1][3]  <= pr;
          9'h023:          kb_q[1][1]  <= pr;
          9'h02B:          kb_q[1][2]  <= pr;
          9'h034:          kb_q[1][0]  <= pr;
          9'h01C:          kb_q[1][4]  <= pr;
          9'h01B:          kb_q[1][5]  <= pr;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pause_d = 1'b0;
    for (int i = 0; i < PLAYERS; i++)
      pause_d = pause_d | io.joy[16*i+9];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause_d;
  end

  assign io.pause     = pause_q;
  assign io.key_reset = key_reset_q;
  assign io.service   = service_q;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    localparam int PN = (p + 1) % PLAYERS;

    logic [15:0]   j;
    logic [7:0]    kb;
    logic [7:0]    raw;
    logic [7:0]    out_d;
    logic [7:0]    ctrl_q;
    logic          coin_prev_q;
    logic [16:0]   coin_cnt_q;
    logic [16:0]   coin_cnt_d;
    af_t           af_q;
    af_t           af_d;
    logic [AW-1:0] afc_q;
    logic [AW-1:0] afc_d;
    logic [AW-1:0] afc_inc;
    logic          fire_d;
    logic          up;
    logic          dn;
    logic          lf;
    logic          rt;
    logic          unused_j;

    assign j        = io.joy[16*p +: 16];
    assign unused_j = ^{j[15:9], j[7]};

    if (p < 2) begin : g_kb
      assign kb = kb_q[p];
    end else begin : g_nokb
      assign kb = '0;
    end

    // Select of the next player (wrapping) feeds this player's start
    assign raw = {j[8], j[6] | io.joy[16*PN+7], j[5:0]} | kb;

    assign up = raw[3] & ~raw[2];
    assign dn = raw[2] & ~raw[3];
    assign lf = raw[1] & ~raw[0];
    assign rt = raw[0] & ~raw[1];

    always_comb begin
      coin_cnt_d = coin_cnt_q;
      if (raw[7] && !coin_prev_q)
        coin_cnt_d = COIN_LOAD;
      else if (coin_cnt_q != '0)
        coin_cnt_d = coin_cnt_q - 17'd1;
    end

    assign afc_inc = afc_q + 1'b1;

    // Output follows the next state so entry and toggles land on the same edge
    always_comb begin
      af_d   = af_q;
      afc_d  = afc_q;
      fire_d = raw[4];
      if (!io.autofire_en[p] || !raw[4]) begin
        af_d  = AF_IDLE;
        afc_d = '0;
      end else begin
        unique case (af_q)
          AF_IDLE: begin
            af_d  = AF_ON;
            afc_d = '0;
          end
          AF_ON, AF_OFF: begin
            if (io.tick) begin
              if (afc_inc == AW'(AF_DIV)) begin
                afc_d = '0;
                af_d  = (af_q == AF_ON) ? AF_OFF : AF_ON;
              end else begin
                afc_d = afc_inc;
              end
            end
          end
          default: af_d = AF_IDLE;
        endcase
        fire_d = (af_d == AF_ON);
      end
    end

    assign out_d = {raw[7] | (coin_cnt_q != '0), raw[6], raw[5],
                    fire_d, up, dn, lf, rt};

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        ctrl_q      <= '0;
        coin_prev_q <= 1'b0;
        coin_cnt_q  <= '0;
        af_q        <= AF_IDLE;
        afc_q       <= '0;
      end else begin
        ctrl_q      <= out_d;
        coin_prev_q <= raw[7];
        coin_cnt_q  <= coin_cnt_d;
        af_q        <= af_d;
        afc_q       <= afc_d;
      end
    end

    assign io.ctrl[8*p +: 8] = ctrl_q;
  end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: keys, joystick merge,
// coin stretch, autofire and reset behaviour.
module tb_arcade_input_mapper;
  localparam int P = 2;

  logic clk_sys = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   hi;
  int   lo;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper_if #(.PLAYERS(P)) bus ();

  arcade_input_mapper #(
    .PLAYERS(P),
    .COIN_MIN_CYCLES(16),
    .AF_DIV(2)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .io(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic key(input logic pr, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pr, code};
  endtask

  // Fire held, tick every 4 cycles at phase ph; t1 = first toggle to OFF
  task automatic af_run(input int ph, input int t1, input string tag);
    int k;
    for (int c = 0; c < 24; c++) begin
      bus.joy[4] = 1'b1;
      bus.tick   = (c % 4 == ph);
      tk(1);
      k = (c < t1) ? 0 : (c - t1) / 8 + 1;
      chk(tag, 32'(bus.ctrl[4]), 32'(k % 2 == 0));
    end
    bus.tick   = 1'b0;
    bus.joy[4] = 1'b0;
    tk(1);
    chk("af_release", 32'(bus.ctrl[4]), 0);
  endtask

  task automatic coin_run(input int c2, input int n, input int exp_len,
                          input string tag);
    hi = 0;
    lo = -1;
    for (int c = 0; c < n; c++) begin
      bus.joy[8] = (c == 0) || (c == c2);
      tk(1);
      if (bus.ctrl[7]) hi++;
      else if (lo < 0) lo = c;
    end
    bus.joy[8] = 1'b0;
    chk({tag, "_len"}, hi, exp_len);
    chk({tag, "_end"}, lo, exp_len);
  endtask

  initial begin
    reset           = 1'b1;
    bus.ps2_key     = '0;
    bus.joy         = 32'h0000_FFFF;
    bus.autofire_en = '0;
    bus.tick        = 1'b0;
    tk(2);
    chk("rst_ctrl", 32'(bus.ctrl), 0);
    chk("rst_pause", 32'(bus.pause), 0);
    chk("rst_krst", 32'(bus.key_reset), 0);
    chk("rst_svc", 32'(bus.service), 0);
    bus.joy = '0;
    reset   = 1'b0;
    tk(1);

    bus.joy = 32'h0000_000C;
    tk(1);
    chk("joy_ud", 32'(bus.ctrl), 0);
    bus.joy = 32'h0000_0008;
    tk(1);
    chk("joy_up", 32'(bus.ctrl), 32'h0008);
    bus.joy = 32'h0000_0003;
    tk(1);
    chk("joy_lr", 32'(bus.ctrl), 0);
    bus.joy = 32'h0000_0005;
    tk(1);
    chk("joy_rd", 32'(bus.ctrl), 32'h0005);
    bus.joy = 32'h0000_0070;
    tk(1);
    chk("joy_fbs", 32'(bus.ctrl), 32'h0070);
    bus.joy = '0;
    tk(1);

    key(1'b1, 9'h175);
    tk(1);
    chk("ps2_lat1", 32'(bus.ctrl), 0);
    tk(1);
    chk("ps2_up_x", 32'(bus.ctrl), 32'h0008);
    key(1'b0, 9'h175);
    tk(2);
    chk("ps2_up_xr", 32'(bus.ctrl), 0);
    key(1'b1, 9'h075);
    tk(2);
    chk("ps2_up", 32'(bus.ctrl), 32'h0008);
    key(1'b0, 9'h075);
    tk(2);
    chk("ps2_upr", 32'(bus.ctrl), 0);
    key(1'b1, 9'h01C);
    tk(2);
    chk("ps2_fire2", 32'(bus.ctrl), 32'h1000);
    key(1'b0, 9'h01C);
    tk(2);
    key(1'b1, 9'h004);
    tk(1);
    chk("krst_on", 32'(bus.key_reset), 1);
    key(1'b0, 9'h004);
    tk(1);
    chk("krst_off", 32'(bus.key_reset), 0);
    key(1'b1, 9'h046);
    tk(1);
    chk("svc_on", 32'(bus.service), 1);
    key(1'b0, 9'h046);
    tk(1);
    key(1'b1, 9'h016);
    tk(2);
    chk("ps2_start1", 32'(bus.ctrl), 32'h0040);
    key(1'b0, 9'h016);
    tk(2);
    key(1'b1, 9'h175);
    bus.joy = 32'h0000_0004;
    tk(2);
    chk("mix_ud", 32'(bus.ctrl), 0);
    key(1'b0, 9'h175);
    tk(2);
    chk("mix_dn", 32'(bus.ctrl), 32'h0004);
    bus.joy = '0;
    key(1'b1, 9'h05A);
    tk(2);
    chk("ps2_unmatched", 32'(bus.ctrl), 0);

    bus.joy = 32'h0080_0000;
    tk(1);
    chk("start_x", 32'(bus.ctrl), 32'h0040);
    bus.joy = 32'h0200_0000;
    tk(1);
    chk("pause", 32'(bus.pause), 1);
    chk("pause_ctrl", 32'(bus.ctrl), 0);
    bus.joy = '0;
    tk(2);

    coin_run(-1, 24, 16, "coin1");
    coin_run(10, 40, 26, "coin2");

    bus.joy[8] = 1'b1;
    tk(1);
    bus.joy[8] = 1'b0;
    tk(5);
    #2 reset = 1'b1;
    #1 chk("rst_mid", 32'(bus.ctrl), 0);
    tk(2);
    reset = 1'b0;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      tk(1);
      if (bus.ctrl[7]) hi++;
    end
    chk("rst_coin", hi, 0);

    bus.autofire_en = 2'b01;
    af_run(3, 7, "af_ph3");
    af_run(0, 8, "af_ph0");

    bus.joy[4] = 1'b1;
    tk(1);
    chk("afm_on", 32'(bus.ctrl[4]), 1);
    bus.tick = 1'b1;
    tk(1);
    chk("afm_t1", 32'(bus.ctrl[4]), 1);
    tk(1);
    chk("afm_off", 32'(bus.ctrl[4]), 0);
    bus.tick        = 1'b0;
    bus.autofire_en = 2'b00;
    tk(1);
    chk("afm_plain", 32'(bus.ctrl[4]), 1);
    bus.autofire_en = 2'b01;
    tk(1);
    chk("afm_reon", 32'(bus.ctrl[4]), 1);
    bus.tick = 1'b1;
    tk(1);
    chk("afm_rt1", 32'(bus.ctrl[4]), 1);
    tk(1);
    chk("afm_roff", 32'(bus.ctrl[4]), 0);
    bus.tick   = 1'b0;
    bus.joy[4] = 1'b0;
    tk(1);
    chk("afm_rel", 32'(bus.ctrl), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised input front-end for arcade cores: merges PS/2 keyboard events and per-player joystick words into registered per-player control bytes.
- Adds coin-pulse stretching, per-player autofire, opposite-direction cleaning and key-based reset/service strobes.
- Sits between hps_io and the game core; replaces ad-hoc key decoding in emu, generalised to N players.

Parameters:
PLAYERS, 2, number of player slots (1..4); keyboard maps P1/P2 only, further players are joystick-only
COIN_MIN_CYCLES, 65536, minimum coin output high time in clk_sys cycles (>=1)
AF_DIV, 4, autofire half-period in tick strobes (>=1)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode
joy  in  16*PLAYERS  joystick p at [16p+:16]: b0 R, b1 L, b2 D, b3 U, b4 fire, b5 bomb, b6 start, b7 select, b8 coin, b9 pause
autofire_en  in  PLAYERS  per-player autofire enable
tick  in  1  one-cycle autofire timebase strobe (e.g. vblank start)
ctrl  out  8*PLAYERS  player p at [8p+:8] = {coin,start,bomb,fire,up,down,left,right}, active high
pause  out  1  OR of joy b9 over all players
key_reset  out  1  level, F3 held
service  out  1  level, key 9 held

Behaviour:
- All outputs registered; every output is 0 in reset. Key latches, coin counters, autofire state clear asynchronously on reset.
- Keyboard latch: old_toggle register. When ps2_key[10] != old_toggle, decode ps2_key[8:0] and write ps2_key[9] to the matched latch.
- Keyboard codes:
  - 016 start1, 01E start2, 02E coin1, 036 coin2, 004 key_reset, 046 service.
  - Arrows (extended bit ignored): x75 up1, x6B left1, x72 down1, x74 right1.
  - 014 fire1, 011 bomb1.
  - P2: 02D up, 023 left, 02B down, 034 right, 01C fire, 01B bomb.
  - Unmatched codes change nothing.
- Latency: joystick change -> ctrl after 1 cycle. PS/2 event -> ctrl after 2 cycles.
- Raw merge per player p: each raw signal = joystick bit OR key latch.
  - start_raw[p] also ORs joy[(p+1) mod PLAYERS] b7. With PLAYERS=1, b7 feeds its own start.
- Direction cleaning: up_raw & down_raw -> both outputs 0. left_raw & right_raw -> both 0. Checked per axis, independently per player.
- Coin stretcher per player: 17-bit down-counter.
  - Rising edge of coin_raw loads COIN_MIN_CYCLES-1.
  - Counter decrements to 0 and saturates there.
  - coin out = coin_raw | (count != 0).
  - A new rising edge while counting reloads the counter.
  - Result: output high >= COIN_MIN_CYCLES cycles.
- Autofire per player, when autofire_en[p]=1:
  - States IDLE, ON, OFF.
  - IDLE --fire_raw--> ON, with fire out = 1 in the same cycle as the plain path.
  - ON/OFF: tick counter increments on tick; when it reaches AF_DIV, it clears and toggles ON<->OFF.
  - fire out = 1 only in ON.
  - fire_raw low in any state -> IDLE, fire out 0, counter 0.
- autofire_en=0: fire out = fire_raw, and the FSM is held in IDLE.
- autofire_en toggling mid-burst: the FSM returns to IDLE on the next cycle; no glitch beyond one cycle.
- tick coinciding with a fire_raw rising edge: the tick is not counted (the counter starts on the following tick).
- pause, key_reset, service: registered, 1-cycle latency, no stretching.

Test Plan:
- Reset asserted mid-coin-stretch (counter=100) -> all ctrl=0 immediately; after release, coin stays 0 with no raw coin.
- ps2_key toggle with code 0x175, pressed=1 -> ctrl[3] (up1) =1 two cycles later; same code with pressed=0 -> ctrl[3]=0. Code 0x075 gives the identical result.
- joy[0] = 0x000C (up+down) -> ctrl[3:2]=00. joy[0]=0x0008 -> ctrl[3]=1 after 1 cycle.
- COIN_MIN_CYCLES=16, 1-cycle joy[0] b8 pulse -> ctrl[7] high exactly 16 cycles. Second pulse at cycle 10 -> high until cycle 10+16.
- AF_DIV=2, autofire_en[0]=1, fire held, tick every 4 cycles -> ctrl[4] pattern 1 for 2 ticks, 0 for 2 ticks, repeating. Release -> 0 next cycle.
- PLAYERS=2, joy[1] b7=1 -> ctrl[6] (P1 start)=1 and ctrl[14]=0. joy[1] b9 -> pause=1.
